// File: rtl/accelerator_buffer_arbiter.sv
// Buffer controller: round-robin write arbiter for requesters A and B, plus a tile read streamer.
// Latency: write grant is combinational (0 cycles); the first stream beat is valid 2 cycles after rd_start, then 1 row per cycle.
// Backpressure: a requester holds its request until its ready; the out_* beat stays stable while out_ready is low.
// Optional feature macro: BUF_ARB_COLLISION_CHECK_EN enables the sticky collision_err flag for same-row read/write.
module accelerator_buffer_arbiter #(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wa_valid,
  output logic                  wa_ready,
  input  logic [ADDR_WIDTH-1:0] wa_addr,
  input  logic [DATA_WIDTH-1:0] wa_data,
  input  logic                  wb_valid,
  output logic                  wb_ready,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  buf_wr_en,
  output logic [ADDR_WIDTH-1:0] buf_wr_addr,
  output logic [DATA_WIDTH-1:0] buf_wr_data,
  output logic [ADDR_WIDTH-1:0] buf_rd_addr,
  input  logic [DATA_WIDTH-1:0] buf_rd_data,
  input  logic                  rd_start,
  input  logic [ADDR_WIDTH-1:0] rd_base,
  input  logic [ADDR_WIDTH:0]   rd_len,
  output logic                  rd_busy,
  output logic                  rd_done,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  collision_err
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_STREAM
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic                  prio_b;
  logic                  grant_a;
  logic                  grant_b;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH:0]   remaining;
  logic                  load_en;
  logic                  last_hs;

  // Grant: a lone requester wins; on contention the side holding priority wins.
  always_comb begin
    grant_a = wa_valid && (!wb_valid || !prio_b);
    grant_b = wb_valid && (!wa_valid || prio_b);
  end

  assign wa_ready  = grant_a;
  assign wb_ready  = grant_b;
  assign buf_wr_en = grant_a || grant_b;

  // Route the granted requester onto the buffer write port; idle port drives zeros.
  always_comb begin
    buf_wr_addr = '0;
    buf_wr_data = '0;
    if (grant_a) begin
      buf_wr_addr = wa_addr;
      buf_wr_data = wa_data;
    end else if (grant_b) begin
      buf_wr_addr = wb_addr;
      buf_wr_data = wb_data;
    end
  end

  // Priority pointer hands priority to the other side after each grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_b <= 1'b0;
    end else if (grant_a) begin
      prio_b <= 1'b1;
    end else if (grant_b) begin
      prio_b <= 1'b0;
    end
  end

  // Output register may take a new row when rows remain and the slot is empty or draining.
  assign load_en     = (state != S_IDLE) && (remaining != '0) && (!out_valid || out_ready);
  assign last_hs     = out_valid && out_ready && out_last;
  assign buf_rd_addr = ptr;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a zero-length tile never leaves IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (rd_start && (rd_len != '0)) state_nxt = S_LOAD;
      S_LOAD:   if (load_en) state_nxt = S_STREAM;
      S_STREAM: if (last_hs) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    rd_busy = (state != S_IDLE);
  end

  // Streamer datapath: address/count tracking, output beat register and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      remaining <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      rd_done   <= 1'b0;
    end else begin
      rd_done <= 1'b0;
      if (state == S_IDLE) begin
        if (rd_start) begin
          ptr       <= rd_base;
          remaining <= rd_len;
          if (rd_len == '0) begin
            rd_done <= 1'b1;
          end
        end
      end else if (last_hs) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        rd_done   <= 1'b1;
      end else if (load_en) begin
        out_valid <= 1'b1;
        out_data  <= buf_rd_data;
        out_last  <= (remaining == (ADDR_WIDTH + 1)'(1));
        ptr       <= (ptr == LAST_ROW) ? '0 : ptr + 1'b1;
        remaining <= remaining - 1'b1;
      end
    end
  end

`ifdef BUF_ARB_COLLISION_CHECK_EN
  // Sticky flag: a write lands on the row being loaded into the stream register in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      collision_err <= 1'b0;
    end else if (buf_wr_en && load_en && (buf_wr_addr == ptr)) begin
      collision_err <= 1'b1;
    end
  end
`else
  assign collision_err = 1'b0;
`endif

endmodule

// File: tb/tb_accelerator_buffer_arbiter.sv
module tb_accelerator_buffer_arbiter;

  localparam int DW    = 128;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          wa_valid, wa_ready, wb_valid, wb_ready;
  logic [AW-1:0] wa_addr, wb_addr;
  logic [DW-1:0] wa_data, wb_data;
  logic          buf_wr_en;
  logic [AW-1:0] buf_wr_addr, buf_rd_addr;
  logic [DW-1:0] buf_wr_data, buf_rd_data;
  logic          rd_start;
  logic [AW-1:0] rd_base;
  logic [AW:0]   rd_len;
  logic          rd_busy, rd_done;
  logic          out_valid, out_ready, out_last;
  logic [DW-1:0] out_data;
  logic          collision_err;

  int checks = 0;
  int errors = 0;
  int hs;
  logic          coll_exp;
  logic [6:0]    rdy_v;
  logic [DW-1:0] exp_d [7];
  logic [6:0]    last_v;

  always #5 clk = ~clk;

  // Buffer memory: registered write, combinational read.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) if (buf_wr_en) mem[buf_wr_addr] <= buf_wr_data;
  assign buf_rd_data = mem[buf_rd_addr];

  accelerator_buffer_arbiter #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .wa_valid(wa_valid), .wa_ready(wa_ready), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
    .buf_rd_addr(buf_rd_addr), .buf_rd_data(buf_rd_data),
    .rd_start(rd_start), .rd_base(rd_base), .rd_len(rd_len),
    .rd_busy(rd_busy), .rd_done(rd_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .collision_err(collision_err)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_a(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wa_valid = 1'b1;
    wa_addr  = a;
    wa_data  = d;
    #1;
    check("preload_wa_ready", wa_ready, 1);
    tick();
    wa_valid = 1'b0;
  endtask

  initial begin
`ifdef BUF_ARB_COLLISION_CHECK_EN
    coll_exp = 1'b1;
`else
    coll_exp = 1'b0;
`endif
    rdy_v  = 7'b1110001;
    last_v = 7'b1000000;
    exp_d  = '{128'h2FE, 128'h2FF, 128'h2FF, 128'h2FF, 128'h2FF, 128'h1000, 128'h1001};

    rst = 1'b1;
    wa_valid = 0; wb_valid = 0; wa_addr = 0; wb_addr = 0; wa_data = 0; wb_data = 0;
    rd_start = 0; rd_base = 0; rd_len = 0; out_ready = 0;
    tick();
    tick();
    #1;
    check("rst_wa_ready", wa_ready, 0);
    check("rst_wb_ready", wb_ready, 0);
    check("rst_wr_en", buf_wr_en, 0);
    check("rst_busy", rd_busy, 0);
    check("rst_done", rd_done, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_rd_addr", buf_rd_addr, 0);
    check("rst_collision", collision_err, 0);
    rst = 1'b0;
    tick();

    // Both requesters valid for 6 cycles: strict alternation starting with A.
    wa_valid = 1; wa_addr = 8'd100;
    wb_valid = 1; wb_addr = 8'd200;
    for (int i = 0; i < 6; i++) begin
      wa_data = DW'(i);
      wb_data = DW'(8'hB0 + i);
      #1;
      check("rr_wa_ready", wa_ready, (i % 2 == 0));
      check("rr_wb_ready", wb_ready, (i % 2 == 1));
      check("rr_wr_en", buf_wr_en, 1);
      check("rr_wr_addr", buf_wr_addr, (i % 2 == 0) ? 100 : 200);
      check("rr_wr_data", buf_wr_data, (i % 2 == 0) ? DW'(i) : DW'(8'hB0 + i));
      tick();
    end
    wa_valid = 0; wb_valid = 0;
    #1;
    check("idle_wr_en", buf_wr_en, 0);
    check("idle_wr_addr", buf_wr_addr, 0);

    // Only B valid: immediate grant; priority then points at A.
    wb_valid = 1; wb_addr = 8'd5; wb_data = 128'hAA;
    #1;
    check("b_only_wb_ready", wb_ready, 1);
    check("b_only_wa_ready", wa_ready, 0);
    check("b_only_wr_addr", buf_wr_addr, 5);
    check("b_only_wr_data", buf_wr_data, 128'hAA);
    tick();
    wa_valid = 1; wa_addr = 8'd50; wa_data = 128'h55;
    wb_valid = 1; wb_addr = 8'd60; wb_data = 128'h66;
    #1;
    check("after_b_wa_ready", wa_ready, 1);
    check("after_b_wb_ready", wb_ready, 0);
    tick();
    wa_valid = 0; wb_valid = 0;
    check("mem_row5", mem[5], 128'hAA);

    // Preload tile rows.
    for (int k = 0; k < 4; k++) write_a(AW'(k), DW'(16'h1000 + k));
    write_a(8'd254, 128'h2FE);
    write_a(8'd255, 128'h2FF);
    write_a(8'd10, 128'hA0);

    // Plain 4-row tile, out_ready held high.
    rd_base = 0; rd_len = 4; out_ready = 1; rd_start = 1;
    #1;
    check("t0_busy", rd_busy, 0);
    check("t0_out_valid", out_valid, 0);
    tick();
    rd_start = 0;
    #1;
    check("t1_busy", rd_busy, 1);
    check("t1_out_valid", out_valid, 0);
    check("t1_rd_addr", buf_rd_addr, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      #1;
      check("tile_valid", out_valid, 1);
      check("tile_data", out_data, DW'(16'h1000 + k));
      check("tile_last", out_last, (k == 3));
      check("tile_no_done", rd_done, 0);
    end
    tick();
    #1;
    check("tile_end_valid", out_valid, 0);
    check("tile_end_done", rd_done, 1);
    check("tile_end_busy", rd_busy, 0);
    tick();
    #1;
    check("tile_done_pulse", rd_done, 0);

    // Wrapping tile with a 3-cycle stall; a rd_start mid-stream is ignored.
    rd_base = 8'd254; rd_len = 4; out_ready = 1; rd_start = 1;
    tick();
    rd_start = 0;
    tick();
    hs = 0;
    for (int c = 0; c < 7; c++) begin
      out_ready = rdy_v[c];
      rd_start  = (c == 1);
      rd_base   = 0;
      rd_len    = 0;
      #1;
      check("wrap_valid", out_valid, 1);
      check("wrap_data", out_data, exp_d[c]);
      check("wrap_last", out_last, last_v[c]);
      check("wrap_no_done", rd_done, 0);
      if (out_valid && out_ready) hs++;
      tick();
    end
    rd_start = 0;
    #1;
    check("wrap_end_valid", out_valid, 0);
    check("wrap_end_done", rd_done, 1);
    check("wrap_handshakes", hs, 4);
    tick();
    #1;
    check("wrap_done_pulse", rd_done, 0);

    // Zero-length tile: done pulse one cycle later, no beats.
    rd_base = 0; rd_len = 0; out_ready = 1; rd_start = 1;
    tick();
    rd_start = 0;
    #1;
    check("zero_done", rd_done, 1);
    check("zero_valid", out_valid, 0);
    check("zero_busy", rd_busy, 0);
    tick();
    #1;
    check("zero_done_pulse", rd_done, 0);
    check("zero_valid2", out_valid, 0);

    // Reset mid-stream.
    rd_base = 0; rd_len = 4; out_ready = 0; rd_start = 1;
    tick();
    rd_start = 0;
    tick();
    #1;
    check("mid_valid", out_valid, 1);
    check("mid_data", out_data, 128'h1000);
    rst = 1;
    tick();
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_busy", rd_busy, 0);
    check("mid_rst_done", rd_done, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_rd_addr", buf_rd_addr, 0);
    rst = 0;
    tick();
    #1;
    check("mid_rst_no_done", rd_done, 0);
    check("mid_rst_valid2", out_valid, 0);

    // Write to row 10 in the same cycle the stream loads row 10.
    rd_base = 8'd10; rd_len = 1; out_ready = 1; rd_start = 1;
    tick();
    rd_start = 0;
    wa_valid = 1; wa_addr = 8'd10; wa_data = 128'hBEEF;
    #1;
    check("coll_wa_ready", wa_ready, 1);
    check("coll_rd_addr", buf_rd_addr, 10);
    tick();
    wa_valid = 0;
    #1;
    check("coll_valid", out_valid, 1);
    check("coll_old_data", out_data, 128'hA0);
    check("coll_last", out_last, 1);
    check("coll_flag", collision_err, coll_exp);
    tick();
    #1;
    check("coll_done", rd_done, 1);
    check("coll_mem_new", mem[10], 128'hBEEF);
    check("coll_sticky", collision_err, coll_exp);
    rst = 1;
    tick();
    rst = 0;
    #1;
    check("coll_cleared", collision_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
